// File: rtl/crc32_stream_if.sv
// Handshake bundle for crc32_stream: framed beat input side and CRC result side.
interface crc32_stream_if #(
  parameter int DATA_WD = 32,
  parameter int NUM_WD  = (DATA_WD / 8 > 1) ? $clog2(DATA_WD / 8) : 1
);
  logic               start_i;
  logic               seed_en_i;
  logic [31:0]        seed_i;
  logic               val_i;
  logic               rdy_o;
  logic [DATA_WD-1:0] dat_i;
  logic [NUM_WD-1:0]  num_i;
  logic               lst_i;
  logic               val_o;
  logic               rdy_i;
  logic [31:0]        dat_o;
  logic [31:0]        raw_o;
  logic               done_o;

  modport master (
    output start_i, seed_en_i, seed_i, val_i, dat_i, num_i, lst_i, rdy_i,
    input  rdy_o, val_o, dat_o, raw_o, done_o
  );

  modport slave (
    input  start_i, seed_en_i, seed_i, val_i, dat_i, num_i, lst_i, rdy_i,
    output rdy_o, val_o, dat_o, raw_o, done_o
  );
endinterface

// File: rtl/crc32_stream.sv
// Streaming PNG/zlib CRC-32 over framed beats of DATA_WD bits with partial beats,
// seed resume and a result held until the consumer accepts it.
module crc32_stream #(
  parameter int          DATA_WD = 32,
  parameter logic [31:0] POLY    = 32'hEDB88320,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT  = 32'hFFFFFFFF
) (
  input logic           clk,
  input logic           rst,
  crc32_stream_if.slave bus
);
  localparam int LANES  = DATA_WD / 8;
  localparam int NUM_WD = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t      state, state_nx;
  logic [31:0] crc, crc_beat, dat_q, raw_q;
  logic        rdy, load, acc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  // Counts above the lane count (non-power-of-two widths) saturate to a full beat.
  function automatic int byte_count(input logic [NUM_WD-1:0] n);
    return (int'(n) > LANES - 1) ? LANES : int'(n) + 1;
  endfunction

  always_comb begin
    logic [31:0] c;
    int          nb;
    crc_beat = crc;
    c        = crc;
    nb       = byte_count(bus.num_i);
    for (int i = 0; i < LANES; i++) begin
      c = crc_byte(c, bus.dat_i[DATA_WD-1-8*i -: 8]);
      if (i + 1 == nb) crc_beat = c;
    end
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    load     = 1'b0;
    acc      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        rdy = ~bus.start_i;
        if (bus.start_i) begin
          load = 1'b1;
        end else if (bus.val_i) begin
          acc = 1'b1;
          if (bus.lst_i) state_nx = OUT;
        end
      end
      OUT: begin
        if (bus.rdy_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      crc   <= INIT;
      dat_q <= '0;
      raw_q <= '0;
    end else begin
      state <= state_nx;
      if (load)     crc <= bus.seed_en_i ? bus.seed_i : INIT;
      else if (acc) crc <= crc_beat;
      if (acc && bus.lst_i) begin
        dat_q <= crc_beat ^ XOROUT;
        raw_q <= crc_beat;
      end
    end
  end

  assign bus.rdy_o  = rdy;
  assign bus.val_o  = (state == OUT);
  assign bus.done_o = (state == OUT) && bus.rdy_i;
  assign bus.dat_o  = dat_q;
  assign bus.raw_o  = raw_q;
endmodule
